// File: rtl/csr_pkg.sv
// csr_pkg: constants and types shared by csr_exec, csr_exec_decode and the
// CSR file.
//   OPC_SYSTEM     SYSTEM major opcode
//   F3_*           funct3 encodings of the six Zicsr instructions
//   CSR_*          machine-mode CSR addresses shared with the CSR file
//   csr_state_e    csr_exec sequencing states
//   f_is_rw        funct3 selects CSRRW/CSRRWI
//   f_skip_write   funct3/src select a set/clear form with a zero source
package csr_pkg;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_WB
    } csr_state_e;

    // CSRRW and CSRRWI share funct3[1:0] == 2'b01
    function automatic logic f_is_rw(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

    // Set/clear with a zero source (x0 or zimm 0) leaves the CSR untouched
    function automatic logic f_skip_write(input logic [2:0] funct3, input logic [4:0] src);
        return !f_is_rw(funct3) && (src == 5'd0);
    endfunction

endpackage

// File: rtl/csr_exec_decode.sv
// csr_exec_decode: combinational classification of a CSR instruction.
//   i_opcode     instr[6:0]
//   i_funct3     instr[14:12]
//   i_rd         instr[11:7]
//   i_src        instr[19:15] (rs1 index or zimm)
//   i_addr_hi    instr[31:30]
//   o_legal      SYSTEM opcode with a Zicsr funct3
//   o_skip_read  CSRRW/CSRRWI with rd = x0: no CSR read
//   o_ro_write   instruction would write a read-only (addr[11:10]==2'b11) CSR
module csr_exec_decode
    import csr_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_src,
    input  logic [1:0] i_addr_hi,
    output logic       o_legal,
    output logic       o_skip_read,
    output logic       o_ro_write
);

    logic w_skip_write;

    assign w_skip_write = f_skip_write(i_funct3, i_src);

    // funct3 values 000 and 100 are the only non-Zicsr encodings
    assign o_legal      = (i_opcode == OPC_SYSTEM) && (i_funct3[1:0] != 2'b00);
    assign o_skip_read  = f_is_rw(i_funct3) && (i_rd == 5'd0);
    assign o_ro_write   = (i_addr_hi == 2'b11) && !w_skip_write;

endmodule

// File: rtl/csr_exec.sv
// csr_exec: sequences one Zicsr instruction against an external CSR file.
// Optional feature: define CSR_EXEC_RO_CHECK_EN to flag writes to read-only
// CSRs (addr[11:10]==2'b11) as illegal instructions.
//   clk, rst       clock, synchronous active-high reset
//   i_valid        instruction offered; accepted when o_ready is high
//   o_ready        idle and able to accept
//   i_instr        instruction word
//   i_rs1_data     rs1 register value
//   csr_addr       CSR address (0 while idle)
//   funct3         {1'b0, instr[14:12]} (0 while idle)
//   o_csr_data     write operand: rs1 data or zero-extended zimm (0 while idle)
//   csr_re/csr_we  CSR file read / write strobes
//   i_csr_rdata    CSR read data, valid the cycle after csr_re
//   o_rd_we        register-file write pulse
//   o_rd_addr      destination register
//   o_rd_data      old CSR value
//   o_illegal      illegal-instruction pulse
module csr_exec
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1_data,
    output logic [11:0]     csr_addr,
    output logic [3:0]      funct3,
    output logic [XLEN-1:0] o_csr_data,
    output logic            csr_re,
    output logic            csr_we,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_rd_we,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_illegal
);

`ifdef CSR_EXEC_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    csr_state_e      r_state;
    csr_state_e      w_state_nxt;
    logic [11:0]     r_addr;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [4:0]      r_src;
    logic [XLEN-1:0] r_operand;
    logic [XLEN-1:0] r_old;
    logic            r_illegal;

    logic w_legal;
    logic w_skip_read;
    logic w_ro_write;
    logic w_illegal;
    logic w_accept;
    logic w_busy;

    csr_exec_decode u_decode (
        .i_opcode    (i_instr[6:0]),
        .i_funct3    (i_instr[14:12]),
        .i_rd        (i_instr[11:7]),
        .i_src       (i_instr[19:15]),
        .i_addr_hi   (i_instr[31:30]),
        .o_legal     (w_legal),
        .o_skip_read (w_skip_read),
        .o_ro_write  (w_ro_write)
    );

    assign w_illegal = !w_legal || (RO_CHECK && w_ro_write);
    assign o_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept  = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_state_nxt = w_skip_read ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:    w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = f_skip_write(r_funct3, r_src) ? ST_WB : ST_WRITE;
            ST_WRITE:   w_state_nxt = ST_WB;
            ST_WB:      w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Fields are latched on every accept; r_old restarts at 0 so a skipped
    // read writes back 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_funct3  <= '0;
            r_rd      <= '0;
            r_src     <= '0;
            r_operand <= '0;
            r_old     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_illegal;
            if (w_accept) begin
                r_addr    <= i_instr[31:20];
                r_funct3  <= i_instr[14:12];
                r_rd      <= i_instr[11:7];
                r_src     <= i_instr[19:15];
                r_operand <= i_instr[14] ? {{(XLEN-5){1'b0}}, i_instr[19:15]} : i_rs1_data;
                r_old     <= '0;
            end else if (r_state == ST_CAPTURE) begin
                r_old <= i_csr_rdata;
            end
        end
    end

    // Every output is gated by rst so the reset cycle is quiet even when
    // the state register still holds an in-flight state.
    assign w_busy     = !rst && (r_state != ST_IDLE);
    assign csr_re     = !rst && (r_state == ST_READ);
    assign csr_we     = !rst && (r_state == ST_WRITE);
    assign o_rd_we    = !rst && (r_state == ST_WB) && (r_rd != 5'd0);
    assign o_illegal  = !rst && r_illegal;
    assign csr_addr   = w_busy ? r_addr : '0;
    assign funct3     = w_busy ? {1'b0, r_funct3} : '0;
    assign o_csr_data = w_busy ? r_operand : '0;
    assign o_rd_addr  = o_rd_we ? r_rd : '0;
    assign o_rd_data  = o_rd_we ? r_old : '0;

endmodule

// File: tb/tb_csr_exec.sv
module tb_csr_exec;

    typedef struct packed {
        logic        re;
        logic        we;
        logic        rdwe;
        logic        ill;
        logic        rdy;
        logic [11:0] addr;
        logic [3:0]  f3;
        logic [31:0] data;
        logic [4:0]  rdaddr;
        logic [31:0] rddata;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs1_data;
    logic [11:0] csr_addr;
    logic [3:0]  funct3;
    logic [31:0] o_csr_data;
    logic        csr_re;
    logic        csr_we;
    logic [31:0] i_csr_rdata;
    logic        o_rd_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_illegal;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] csr_mem [4096];
    obs_t        exp_q [$];
    obs_t        cur_exp = '0;

    csr_exec #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_instr     (i_instr),
        .i_rs1_data  (i_rs1_data),
        .csr_addr    (csr_addr),
        .funct3      (funct3),
        .o_csr_data  (o_csr_data),
        .csr_re      (csr_re),
        .csr_we      (csr_we),
        .i_csr_rdata (i_csr_rdata),
        .o_rd_we     (o_rd_we),
        .o_rd_addr   (o_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_illegal   (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: CSR file with registered read and set/clear merge
    always @(posedge clk) begin
        if (csr_re) i_csr_rdata <= csr_mem[csr_addr];
        if (csr_we) begin
            case (funct3[1:0])
                2'b01:   csr_mem[csr_addr] <= o_csr_data;
                2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | o_csr_data;
                2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~o_csr_data;
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [11:0] addr, input logic [4:0] src);
        return {addr, src, f3, rd, 7'h73};
    endfunction

    // Model: expand one accepted instruction into its per-cycle observations
    task automatic push_txn(input logic [31:0] ins, input logic [31:0] rs1);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  src;
        logic [11:0] addr;
        logic        legal, is_rw, reads, writes;
        obs_t        busy, e;
        op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7]; src = ins[19:15]; addr = ins[31:20];
        legal  = (op == 7'h73) && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3 ||
                                   f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7);
        is_rw  = (f3 == 3'd1) || (f3 == 3'd5);
        reads  = !(is_rw && rd == 5'd0);
        writes = is_rw || (src != 5'd0);
`ifdef CSR_EXEC_RO_CHECK_EN
        if (writes && addr >= 12'hC00) legal = 1'b0;
`endif
        if (!legal) begin
            e = '0; e.ill = 1'b1; e.rdy = 1'b1;
            exp_q.push_back(e);
            return;
        end
        busy = '0;
        busy.addr = addr;
        busy.f3   = {1'b0, f3};
        busy.data = (f3 >= 3'd4) ? {27'd0, src} : rs1;
        if (reads) begin
            e = busy; e.re = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(busy);
        end
        if (writes) begin
            e = busy; e.we = 1'b1;
            exp_q.push_back(e);
        end
        e = busy;
        if (rd != 5'd0) begin
            e.rdwe = 1'b1; e.rdaddr = rd;
            e.rddata = reads ? csr_mem[addr] : 32'd0;
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst) exp_q.delete();
        else if (i_valid && cur_exp.rdy) push_txn(i_instr, i_rs1_data);
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (rst) begin
            exp_q.delete();
            e = '0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0; e.rdy = 1'b1;
        end
        cur_exp = e;
        a = {csr_re, csr_we, o_rd_we, o_illegal, o_ready, csr_addr, funct3,
             o_csr_data, o_rd_addr, o_rd_data};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t actual=%h expected=%h", $time, a, e);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs1);
        @(posedge clk); #1;
        i_valid = 1'b1; i_instr = ins; i_rs1_data = rs1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_rs1_data = '0; i_csr_rdata = '0;
        for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
        csr_mem[12'h305] = 32'h100;
        csr_mem[12'h342] = 32'hB;

        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, o_ready}, 32'd0);
        chk("reset_addr", {20'd0, csr_addr}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, o_ready}, 32'd1);

        // CSRRW x5, mtvec, x6 with a stray i_valid while busy
        issue(csr_i(3'b001, 5'd5, 12'h305, 5'd6), 32'h200);
        @(negedge clk);
        chk("s1_re_c1", {31'd0, csr_re}, 32'd1);
        chk("s1_addr_c1", {20'd0, csr_addr}, 32'h305);
        @(posedge clk); #1; i_valid = 1'b1; i_instr = 32'h0000_0033;
        @(negedge clk);
        @(posedge clk); #1; i_valid = 1'b0;
        @(negedge clk);
        chk("s1_we_c3", {31'd0, csr_we}, 32'd1);
        chk("s1_data_c3", o_csr_data, 32'h200);
        chk("s1_noill_c3", {31'd0, o_illegal}, 32'd0);
        @(negedge clk);
        chk("s1_rdwe_c4", {31'd0, o_rd_we}, 32'd1);
        chk("s1_rdaddr_c4", {27'd0, o_rd_addr}, 32'd5);
        chk("s1_rddata_c4", o_rd_data, 32'h100);
        settle();
        chk("s1_mtvec", csr_mem[12'h305], 32'h200);

        // CSRRWI x0, mscratch, 7
        issue(csr_i(3'b101, 5'd0, 12'h340, 5'd7), 32'hFFFF_FFFF);
        @(negedge clk);
        chk("s2_we_c1", {30'd0, csr_re, csr_we}, 32'd1);
        chk("s2_data_c1", o_csr_data, 32'h7);
        @(negedge clk);
        chk("s2_nordwe_c2", {31'd0, o_rd_we}, 32'd0);
        @(negedge clk);
        chk("s2_ready_c3", {31'd0, o_ready}, 32'd1);
        settle();
        chk("s2_mscratch", csr_mem[12'h340], 32'h7);

        // CSRRS x3, mcause, x0
        issue(csr_i(3'b010, 5'd3, 12'h342, 5'd0), 32'hDEAD_BEEF);
        @(negedge clk);
        chk("s3_re_c1", {31'd0, csr_re}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("s3_rdwe_c3", {30'd0, csr_we, o_rd_we}, 32'd1);
        chk("s3_rddata_c3", o_rd_data, 32'hB);
        @(negedge clk);
        chk("s3_ready_c4", {31'd0, o_ready}, 32'd1);
        settle();

        // Illegal: funct3=100, then opcode 0x33
        issue(csr_i(3'b100, 5'd1, 12'h300, 5'd1), 32'h1);
        @(negedge clk);
        chk("s4a_ill_c1", {28'd0, o_illegal, csr_re, csr_we, o_rd_we}, 32'h8);
        settle();
        issue({12'h305, 5'd6, 3'b001, 5'd5, 7'h33}, 32'h1);
        @(negedge clk);
        chk("s4b_ill_c1", {28'd0, o_illegal, csr_re, csr_we, o_rd_we}, 32'h8);
        settle();

        // Reset while in CAPTURE
        issue(csr_i(3'b001, 5'd7, 12'h341, 5'd8), 32'h77);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_quiet", {29'd0, csr_re, csr_we, o_ready}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("s5_ready_after", {31'd0, o_ready}, 32'd1);
        chk("s5_quiet_after", {28'd0, csr_we, o_rd_we, o_illegal, csr_re}, 32'd0);
        chk("s5_addr_zero", {20'd0, csr_addr}, 32'd0);
        settle();
        chk("s5_mepc_untouched", csr_mem[12'h341], 32'd0);

        // CSRRW x1, cycle(0xC00), x2
        issue(csr_i(3'b001, 5'd1, 12'hC00, 5'd2), 32'h55);
`ifdef CSR_EXEC_RO_CHECK_EN
        @(negedge clk);
        chk("s6_ro_ill", {30'd0, o_illegal, csr_re}, 32'h2);
        settle();
        chk("s6_ro_mem", csr_mem[12'hC00], 32'd0);
`else
        repeat (3) @(negedge clk);
        chk("s6_we_c3", {31'd0, csr_we}, 32'd1);
        settle();
        chk("s6_mem", csr_mem[12'hC00], 32'h55);
`endif

        // Further vectors checked by the per-cycle model
        issue(csr_i(3'b011, 5'd4, 12'h305, 5'd9), 32'h200);
        settle();
        issue(csr_i(3'b110, 5'd0, 12'h340, 5'd0), 32'h0);
        settle();
        issue(csr_i(3'b111, 5'd2, 12'h340, 5'd3), 32'h0);
        settle();
        issue(csr_i(3'b101, 5'd9, 12'h342, 5'h1F), 32'h0);
        settle();
        issue(csr_i(3'b010, 5'd0, 12'h342, 5'd1), 32'h10);
        settle();
        chk("t_mtvec_cleared", csr_mem[12'h305], 32'h0);
        chk("t_mscratch_rci", csr_mem[12'h340], 32'h4);
        chk("t_mcause", csr_mem[12'h342], 32'h1F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
